// File: rtl/rt_trav_pkg.sv
// rtl/rt_trav_pkg.sv - shared types and constants for BVH slab traversal
// Contents: Q16.16 scalar, node index, child box layout, stack entry, FSM state encoding.
package rt_trav_pkg;

  localparam int          NODE_IDX_W = 24;
  localparam logic [31:0] Q16_ONE    = 32'h0001_0000;

  typedef logic signed [31:0]    q16_t;
  typedef logic [NODE_IDX_W-1:0] node_idx_t;

  // Member order puts xmin in the least significant word, matching the
  // {zmax,ymax,xmax,zmin,ymin,xmin} bus layout from the node cache.
  typedef struct packed {
    q16_t zmax;
    q16_t ymax;
    q16_t xmax;
    q16_t zmin;
    q16_t ymin;
    q16_t xmin;
  } box_t;

  typedef struct packed {
    node_idx_t idx;
    logic      leaf;
    q16_t      t_near;
  } stack_ent_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_WAITN,
    S_TEST0,
    S_TEST1,
    S_COLLECT,
    S_DECIDE,
    S_NEXT,
    S_EMIT,
    S_POP,
    S_DONE
  } trav_state_t;

endpackage

// File: rtl/trav_stack.sv
// rtl/trav_stack.sv - synchronous LIFO holding deferred far children
// Ports: clk/rst; push/push_data write; pop discards top; top_data shows the
// current top; full/empty status; drop flags a push that was discarded because full.
module trav_stack #(
  parameter int W     = 57,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  sp;
  logic [AW:0]  sp_m1;

  assign sp_m1    = sp - 1'b1;
  assign full     = (sp == (AW+1)'(DEPTH));
  assign empty    = (sp == '0);
  assign drop     = push && full;
  assign top_data = mem[sp_m1[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else begin
      if (push && !full) begin
        mem[sp[AW-1:0]] <= push_data;
        sp              <= sp + 1'b1;
      end else if (pop && !empty) begin
        sp <= sp_m1;
      end
    end
  end

  // The traversal FSM never pushes and pops in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && pop));
    end
  end

endmodule

// File: rtl/bvh_slab_traverser.sv
// rtl/bvh_slab_traverser.sv - BVH traversal initiator feeding a ray/box slab tester
// Ports: ray_* accepts one ray; node_req_*/node_rsp_* fetch nodes from the cache;
// slab_* issues child boxes and takes hit/t results one cycle later; leaf_* hands
// hit leaves to the triangle stage; done_* reports completion and stack overflow.
module bvh_slab_traverser
  import rt_trav_pkg::*;
#(
  parameter int IDX_W       = 24,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ray_valid,
  output logic              ray_ready,
  input  logic [95:0]       ray_o,
  input  logic [95:0]       ray_inv,
  input  logic [31:0]       ray_tmax,
  input  logic [IDX_W-1:0]  ray_root,
  output logic              node_req_valid,
  input  logic              node_req_ready,
  output logic [IDX_W-1:0]  node_req_addr,
  input  logic              node_rsp_valid,
  input  logic [191:0]      node_rsp_box0,
  input  logic [191:0]      node_rsp_box1,
  input  logic [IDX_W-1:0]  node_rsp_child0,
  input  logic [IDX_W-1:0]  node_rsp_child1,
  input  logic [1:0]        node_rsp_leaf,
  output logic              slab_valid,
  output logic [191:0]      slab_box,
  output logic [95:0]       slab_o,
  output logic [95:0]       slab_inv,
  input  logic              slab_rsp_valid,
  input  logic              slab_hit,
  input  logic [31:0]       slab_t_near,
  input  logic [31:0]       slab_t_far,
  output logic              leaf_valid,
  input  logic              leaf_ready,
  output logic [IDX_W-1:0]  leaf_idx,
  output logic [31:0]       leaf_t_near,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              done_overflow
);

  localparam int ENT_W = IDX_W + 1 + 32;

  trav_state_t st, st_nxt;

  logic [95:0]      ray_o_q, ray_inv_q;
  q16_t             tmax_q;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_leaf;
  q16_t             cur_t;
  box_t             box0_q, box1_q;
  logic [IDX_W-1:0] c0_q, c1_q;
  logic [1:0]       leaf_q;
  logic             hit0_q, hit1_q;
  q16_t             tn0_q, tn1_q;
  logic             ovf_q;

  logic             acc0, acc1, near0;
  logic             push, pop, full, empty, drop;
  logic [ENT_W-1:0] push_data, top_data;

  // Exit distance is not needed: acceptance only looks at entry distance.
  logic unused_t_far;
  assign unused_t_far = ^slab_t_far;

  assign acc0  = hit0_q && (tn0_q <= tmax_q);
  assign acc1  = hit1_q && (tn1_q <= tmax_q);
  assign near0 = (tn0_q <= tn1_q);

  assign push      = (st == S_DECIDE) && acc0 && acc1;
  assign pop       = (st == S_POP) && !empty;
  assign push_data = near0 ? {c1_q, leaf_q[1], tn1_q} : {c0_q, leaf_q[0], tn0_q};

  trav_stack #(
    .W     (ENT_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty),
    .drop      (drop)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt         = st;
    ray_ready      = 1'b0;
    node_req_valid = 1'b0;
    slab_valid     = 1'b0;
    slab_box       = '0;
    leaf_valid     = 1'b0;
    done_valid     = 1'b0;
    case (st)
      S_IDLE: begin
        ray_ready = 1'b1;
        if (ray_valid) st_nxt = S_FETCH;
      end
      S_FETCH: begin
        node_req_valid = 1'b1;
        if (node_req_ready) st_nxt = S_WAITN;
      end
      S_WAITN:   if (node_rsp_valid) st_nxt = S_TEST0;
      S_TEST0: begin
        slab_valid = 1'b1;
        slab_box   = box0_q;
        st_nxt     = S_TEST1;
      end
      S_TEST1: begin
        slab_valid = 1'b1;
        slab_box   = box1_q;
        st_nxt     = S_COLLECT;
      end
      S_COLLECT: st_nxt = S_DECIDE;
      S_DECIDE:  st_nxt = (acc0 || acc1) ? S_NEXT : S_POP;
      S_NEXT:    st_nxt = cur_leaf ? S_EMIT : S_FETCH;
      S_EMIT: begin
        leaf_valid = 1'b1;
        if (leaf_ready) st_nxt = S_POP;
      end
      S_POP:     st_nxt = empty ? S_DONE : S_NEXT;
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) st_nxt = S_IDLE;
      end
      default:   st_nxt = S_IDLE;
    endcase
  end

  assign node_req_addr = cur_idx;
  assign leaf_idx      = cur_idx;
  assign leaf_t_near   = cur_t;
  assign slab_o        = ray_o_q;
  assign slab_inv      = ray_inv_q;
  assign done_overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ray_o_q   <= '0;
      ray_inv_q <= '0;
      tmax_q    <= '0;
      cur_idx   <= '0;
      cur_leaf  <= 1'b0;
      cur_t     <= '0;
      box0_q    <= '0;
      box1_q    <= '0;
      c0_q      <= '0;
      c1_q      <= '0;
      leaf_q    <= '0;
      hit0_q    <= 1'b0;
      hit1_q    <= 1'b0;
      tn0_q     <= '0;
      tn1_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (st)
        S_IDLE: if (ray_valid) begin
          ray_o_q   <= ray_o;
          ray_inv_q <= ray_inv;
          tmax_q    <= ray_tmax;
          cur_idx   <= ray_root;
          cur_leaf  <= 1'b0;     // the root is always fetched, never emitted
          cur_t     <= '0;
          ovf_q     <= 1'b0;
        end
        S_WAITN: if (node_rsp_valid) begin
          box0_q <= node_rsp_box0;
          box1_q <= node_rsp_box1;
          c0_q   <= node_rsp_child0;
          c1_q   <= node_rsp_child1;
          leaf_q <= node_rsp_leaf;
        end
        // A missing result pulse leaves the child marked as a miss.
        S_TEST0: begin
          hit0_q <= 1'b0;
          hit1_q <= 1'b0;
        end
        S_TEST1: if (slab_rsp_valid) begin
          hit0_q <= slab_hit;
          tn0_q  <= slab_t_near;
        end
        S_COLLECT: if (slab_rsp_valid) begin
          hit1_q <= slab_hit;
          tn1_q  <= slab_t_near;
        end
        S_DECIDE: begin
          if (acc0 && (!acc1 || near0)) begin
            cur_idx  <= c0_q;
            cur_leaf <= leaf_q[0];
            cur_t    <= tn0_q;
          end else if (acc1) begin
            cur_idx  <= c1_q;
            cur_leaf <= leaf_q[1];
            cur_t    <= tn1_q;
          end
          if (drop) ovf_q <= 1'b1;
        end
        S_POP: if (!empty) begin
          cur_idx  <= top_data[ENT_W-1 -: IDX_W];
          cur_leaf <= top_data[32];
          cur_t    <= top_data[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bvh_slab_traverser.sv
// tb/tb_bvh_slab_traverser.sv - directed self-checking bench for bvh_slab_traverser
module tb_bvh_slab_traverser;
  import rt_trav_pkg::*;

  localparam int IDX_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ray_valid = 1'b0;
  logic              ray_ready;
  logic [95:0]       ray_o = 96'h0003_0000_0002_0000_0001_0000;
  logic [95:0]       ray_inv = 96'h0000_8000_0001_0000_0002_0000;
  logic [31:0]       ray_tmax = '0;
  logic [IDX_W-1:0]  ray_root = '0;
  logic              node_req_valid;
  logic              node_req_ready = 1'b1;
  logic [IDX_W-1:0]  node_req_addr;
  logic              node_rsp_valid = 1'b0;
  logic [191:0]      node_rsp_box0 = '0;
  logic [191:0]      node_rsp_box1 = '0;
  logic [IDX_W-1:0]  node_rsp_child0 = '0;
  logic [IDX_W-1:0]  node_rsp_child1 = '0;
  logic [1:0]        node_rsp_leaf = '0;
  logic              slab_valid;
  logic [191:0]      slab_box;
  logic [95:0]       slab_o;
  logic [95:0]       slab_inv;
  logic              slab_rsp_valid = 1'b0;
  logic              slab_hit = 1'b0;
  logic [31:0]       slab_t_near = '0;
  logic [31:0]       slab_t_far = '0;
  logic              leaf_valid;
  logic              leaf_ready = 1'b1;
  logic [IDX_W-1:0]  leaf_idx;
  logic [31:0]       leaf_t_near;
  logic              done_valid;
  logic              done_ready = 1'b0;
  logic              done_overflow;

  bvh_slab_traverser #(.IDX_W(IDX_W), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_o(ray_o), .ray_inv(ray_inv),
    .ray_tmax(ray_tmax), .ray_root(ray_root),
    .node_req_valid(node_req_valid), .node_req_ready(node_req_ready), .node_req_addr(node_req_addr),
    .node_rsp_valid(node_rsp_valid), .node_rsp_box0(node_rsp_box0), .node_rsp_box1(node_rsp_box1),
    .node_rsp_child0(node_rsp_child0), .node_rsp_child1(node_rsp_child1), .node_rsp_leaf(node_rsp_leaf),
    .slab_valid(slab_valid), .slab_box(slab_box), .slab_o(slab_o), .slab_inv(slab_inv),
    .slab_rsp_valid(slab_rsp_valid), .slab_hit(slab_hit), .slab_t_near(slab_t_near), .slab_t_far(slab_t_far),
    .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .leaf_idx(leaf_idx), .leaf_t_near(leaf_t_near),
    .done_valid(done_valid), .done_ready(done_ready), .done_overflow(done_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Node memory model: internal nodes 0..15; box xmin encodes {addr, child}.
  logic [IDX_W-1:0] c0_tab [16];
  logic [IDX_W-1:0] c1_tab [16];
  logic [1:0]       lf_tab [16];
  logic [1:0]       hit_tab [16];
  logic [31:0]      tn_tab [16][2];
  int               node_lat = 1;

  int               rsp_cnt = 0;
  logic [IDX_W-1:0] rsp_addr = '0;
  int               req_count = 0;

  always @(negedge clk) begin
    node_rsp_valid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        node_rsp_valid  = 1'b1;
        node_rsp_box0   = {160'h0, 27'h0, rsp_addr[3:0], 1'b0};
        node_rsp_box1   = {160'h0, 27'h0, rsp_addr[3:0], 1'b1};
        node_rsp_child0 = c0_tab[rsp_addr[3:0]];
        node_rsp_child1 = c1_tab[rsp_addr[3:0]];
        node_rsp_leaf   = lf_tab[rsp_addr[3:0]];
      end
    end
    if (node_req_valid && node_req_ready) begin
      rsp_cnt  = node_lat;
      rsp_addr = node_req_addr;
      req_count++;
    end
  end

  // Slab model: result one cycle after issue; tracks issue order and ray operands.
  logic        s_pend = 1'b0;
  logic [31:0] s_id = '0;
  logic        s_par = 1'b0;
  int          order_err = 0;
  int          issue_count = 0;
  logic [95:0] seen_o = '0;
  logic [95:0] seen_inv = '0;

  always @(negedge clk) begin
    slab_rsp_valid = s_pend;
    if (s_pend) begin
      slab_hit    = hit_tab[s_id[4:1]][s_id[0]];
      slab_t_near = tn_tab[s_id[4:1]][s_id[0]];
      slab_t_far  = slab_t_near + Q16_ONE;
    end
    s_pend = slab_valid;
    if (slab_valid) begin
      s_id = slab_box[31:0];
      if (s_id[0] !== s_par) order_err++;
      s_par = ~s_par;
      issue_count++;
      seen_o   = slab_o;
      seen_inv = slab_inv;
    end
  end

  logic [IDX_W-1:0] got_idx [$];
  logic [31:0]      got_t   [$];
  logic [IDX_W-1:0] exp_idx [$];
  logic [31:0]      exp_t   [$];

  always @(negedge clk) begin
    if (leaf_valid && leaf_ready) begin
      got_idx.push_back(leaf_idx);
      got_t.push_back(leaf_t_near);
    end
  end

  logic seen_ovf;

  task automatic clear_tabs();
    for (int i = 0; i < 16; i++) begin
      c0_tab[i] = '0; c1_tab[i] = '0; lf_tab[i] = 2'b00; hit_tab[i] = 2'b00;
      tn_tab[i][0] = '0; tn_tab[i][1] = '0;
    end
  endtask

  task automatic run_ray(input string tag, input logic [IDX_W-1:0] root, input logic [31:0] tmax);
    int cyc;
    got_idx.delete(); got_t.delete();
    req_count = 0; issue_count = 0; order_err = 0;
    @(posedge clk); #1;
    ray_root = root; ray_tmax = tmax; ray_valid = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ray_ready"}, ray_ready, 1'b1);
    @(posedge clk); #1;
    ray_valid = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (done_valid) break;
      cyc++;
    end
    check_eq({tag, "_done_seen"}, done_valid, 1'b1);
    seen_ovf = done_overflow;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_idle_ready"}, ray_ready, 1'b1);
    check_eq({tag, "_done_drop"}, done_valid, 1'b0);
    check_eq({tag, "_box_order"}, order_err, 0);
    if (issue_count > 0) begin
      check_eq({tag, "_slab_o"}, seen_o, ray_o);
      check_eq({tag, "_slab_inv"}, seen_inv, ray_inv);
    end
  endtask

  task automatic check_leaves(input string tag, input logic exp_ovf);
    check_eq({tag, "_leaf_count"}, got_idx.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      check_eq($sformatf("%s_leaf%0d_idx", tag, i), got_idx[i], exp_idx[i]);
      check_eq($sformatf("%s_leaf%0d_t", tag, i), got_t[i], exp_t[i]);
    end
    check_eq({tag, "_overflow"}, seen_ovf, exp_ovf);
  endtask

  task automatic setup_pair(input logic [1:0] hits, input logic [31:0] t0, input logic [31:0] t1);
    clear_tabs();
    c0_tab[0] = 24'd1; c1_tab[0] = 24'd2; lf_tab[0] = 2'b11;
    hit_tab[0] = hits; tn_tab[0][0] = t0; tn_tab[0][1] = t1;
  endtask

  localparam logic [31:0] TMAX = 32'h0064_0000;

  logic [IDX_W-1:0] hold_idx;
  logic [31:0]      hold_t;
  int               cnt_bad;

  initial begin
    clear_tabs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ray_ready", ray_ready, 1'b1);
    check_eq("rst_node_req", node_req_valid, 1'b0);
    check_eq("rst_slab_valid", slab_valid, 1'b0);
    check_eq("rst_leaf_valid", leaf_valid, 1'b0);
    check_eq("rst_done_valid", done_valid, 1'b0);
    check_eq("rst_overflow", done_overflow, 1'b0);
    check_eq("rst_addr", node_req_addr, 24'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Near-far ordering: child1 is nearer.
    setup_pair(2'b11, 32'h0008_0000, 32'h0006_0000);
    exp_idx = '{24'd2, 24'd1}; exp_t = '{32'h0006_0000, 32'h0008_0000};
    run_ray("order", 24'd0, TMAX);
    check_leaves("order", 1'b0);
    check_eq("order_reqs", req_count, 1);

    // Tie: child0 goes first.
    setup_pair(2'b11, 32'h0005_0000, 32'h0005_0000);
    exp_idx = '{24'd1, 24'd2}; exp_t = '{32'h0005_0000, 32'h0005_0000};
    run_ray("tie", 24'd0, TMAX);
    check_leaves("tie", 1'b0);

    // Negative entry distance must be signed-ordered ahead of a positive one.
    setup_pair(2'b11, 32'h0003_0000, 32'hFFFF_0000);
    exp_idx = '{24'd2, 24'd1}; exp_t = '{32'hFFFF_0000, 32'h0003_0000};
    run_ray("signed", 24'd0, TMAX);
    check_leaves("signed", 1'b0);

    // Child1 hits beyond tmax, child0 misses.
    setup_pair(2'b10, 32'h0001_0000, 32'h0070_0000);
    exp_idx.delete(); exp_t.delete();
    run_ray("beyond", 24'd0, TMAX);
    check_leaves("beyond", 1'b0);
    check_eq("beyond_reqs", req_count, 1);

    // Root misses both children.
    setup_pair(2'b00, 32'h0001_0000, 32'h0002_0000);
    run_ray("miss", 24'd3, TMAX);
    check_leaves("miss", 1'b0);
    check_eq("miss_reqs", req_count, 1);
    check_eq("miss_issues", issue_count, 2);

    // Left-deep chain of 10 internal nodes: 8 far leaves fit, 2 dropped.
    clear_tabs();
    for (int k = 0; k < 10; k++) begin
      c0_tab[k] = 24'(k + 1); c1_tab[k] = 24'(100 + k);
      lf_tab[k] = (k == 9) ? 2'b11 : 2'b10;
      hit_tab[k] = 2'b11; tn_tab[k][0] = Q16_ONE; tn_tab[k][1] = 32'h0002_0000;
    end
    exp_idx = '{24'd10, 24'd107, 24'd106, 24'd105, 24'd104, 24'd103, 24'd102, 24'd101, 24'd100};
    exp_t   = '{Q16_ONE, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000,
                32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000};
    run_ray("chain", 24'd0, TMAX);
    check_leaves("chain", 1'b1);
    check_eq("chain_reqs", req_count, 10);

    // Overflow flag is per ray.
    setup_pair(2'b01, 32'h0004_0000, 32'h0002_0000);
    exp_idx = '{24'd1}; exp_t = '{32'h0004_0000};
    run_ray("ovf_clear", 24'd0, TMAX);
    check_leaves("ovf_clear", 1'b0);

    // Leaf backpressure: outputs hold while leaf_ready is low.
    setup_pair(2'b11, 32'h0008_0000, 32'h0006_0000);
    exp_idx = '{24'd2, 24'd1}; exp_t = '{32'h0006_0000, 32'h0008_0000};
    leaf_ready = 1'b0;
    fork
      run_ray("stall", 24'd0, TMAX);
      begin
        int w;
        w = 0;
        while (!leaf_valid && w < 200) begin
          @(negedge clk);
          w++;
        end
        check_eq("stall_leaf_seen", leaf_valid, 1'b1);
        hold_idx = leaf_idx; hold_t = leaf_t_near;
        check_eq("stall_first_idx", hold_idx, 24'd2);
        cnt_bad = 0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (!leaf_valid || leaf_idx !== hold_idx || leaf_t_near !== hold_t) cnt_bad++;
        end
        check_eq("stall_stable", cnt_bad, 0);
        leaf_ready = 1'b1;
      end
    join
    check_leaves("stall", 1'b0);

    // Reset while waiting on the node cache.
    setup_pair(2'b11, 32'h0008_0000, 32'h0006_0000);
    node_lat = 4;
    got_idx.delete();
    @(posedge clk); #1;
    ray_root = 24'd5; ray_valid = 1'b1;
    @(posedge clk); #1;
    ray_valid = 1'b0;
    begin
      int w;
      w = 0;
      while (!node_req_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      check_eq("rwait_req_seen", node_req_valid, 1'b1);
    end
    @(posedge clk); #1;
    check_eq("rwait_ready_low", ray_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rwait_ray_ready", ray_ready, 1'b1);
    check_eq("rwait_node_req", node_req_valid, 1'b0);
    check_eq("rwait_addr", node_req_addr, 24'd0);
    check_eq("rwait_slab", slab_valid, 1'b0);
    check_eq("rwait_overflow", done_overflow, 1'b0);
    cnt_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_valid || leaf_valid || slab_valid || !ray_ready) cnt_bad++;
    end
    check_eq("rwait_quiet", cnt_bad, 0);
    check_eq("rwait_no_leaf", got_idx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
